// File: rtl/xmit_frame_gen.sv
// Burst frame generator: HEAD/BODY/TAIL beats with a valid/ready handshake.
// Define XMIT_FRAME_GEN_SEQ_EN to fill BODY beats with a running sequence.
module xmit_frame_gen #(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 12,
    parameter int CNT_W    = 16,
    parameter int MARK_LEN = 4,
    parameter int GAP_W    = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_pri_mode,
    input  logic              f_ready,
    output logic [DATA_W-1:0] f_data_in,
    output logic              f_rec_data_valid,
    output logic [23:0]       f_ctrl_in,
    output logic              f_rec_frame_valid,
    output logic              f_hi_priority,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, GAP, DONE} state_t;

    localparam logic [LEN_W-1:0]  MARK_L = LEN_W'(MARK_LEN);
    localparam logic [LEN_W-1:0]  MIN_L  = LEN_W'(2 * MARK_LEN);
    localparam logic [DATA_W-1:0] MARKER = '1;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   num_q;
    logic [GAP_W-1:0]   gap_q;
    logic [1:0]         mode_q;
    logic [LEN_W-1:0]   bcnt;
    logic [GAP_W-1:0]   gcnt;

    logic [LEN_W-1:0]   cfg_eff;
    logic [LEN_W-1:0]   nxt;
    logic [CNT_W-1:0]   frame_nxt;
    logic               last;
    state_t             nst;
    logic [DATA_W-1:0]  body_val;
    logic [DATA_W-1:0]  nxt_data;
    logic               xfer;

    function automatic logic pri_of(input logic [1:0] m, input logic k0);
        unique case (m)
            2'd0:    pri_of = 1'b0;
            2'd1:    pri_of = 1'b1;
            2'd2:    pri_of = ~k0;
            default: pri_of = k0;
        endcase
    endfunction

    assign cfg_eff   = (cfg_len < MIN_L) ? MIN_L : cfg_len;
    assign nxt       = bcnt + LEN_W'(1);
    assign frame_nxt = frame_cnt + CNT_W'(1);
    assign last      = (bcnt == len_q - LEN_W'(1));
    assign xfer      = f_rec_data_valid && f_ready;

`ifdef XMIT_FRAME_GEN_SEQ_EN
    assign body_val = DATA_W'(frame_cnt) + DATA_W'(nxt - MARK_L);
`else
    assign body_val = '0;
`endif

    always_comb begin
        nst = TAIL;
        if (nxt < MARK_L)
            nst = HEAD;
        else if (nxt < len_q - MARK_L)
            nst = BODY;
        nxt_data = (nst == BODY) ? body_val : MARKER;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state             <= IDLE;
            len_q             <= '0;
            num_q             <= '0;
            gap_q             <= '0;
            mode_q            <= '0;
            bcnt              <= '0;
            gcnt              <= '0;
            f_data_in         <= '0;
            f_rec_data_valid  <= 1'b0;
            f_ctrl_in         <= '0;
            f_rec_frame_valid <= 1'b0;
            f_hi_priority     <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            frame_cnt         <= '0;
        end else if (abort && state != IDLE) begin
            // frame_cnt keeps the count of completed frames
            state             <= IDLE;
            f_data_in         <= '0;
            f_rec_data_valid  <= 1'b0;
            f_ctrl_in         <= '0;
            f_rec_frame_valid <= 1'b0;
            f_hi_priority     <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        len_q     <= cfg_eff;
                        num_q     <= cfg_num;
                        gap_q     <= cfg_gap;
                        mode_q    <= cfg_pri_mode;
                        frame_cnt <= '0;
                        bcnt      <= '0;
                        busy      <= 1'b1;
                        if (cfg_num == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state             <= HEAD;
                            f_data_in         <= MARKER;
                            f_rec_data_valid  <= 1'b1;
                            f_rec_frame_valid <= 1'b1;
                            f_ctrl_in         <= {cfg_eff, cfg_eff};
                            f_hi_priority     <= pri_of(cfg_pri_mode, 1'b0);
                        end
                    end
                end
                HEAD, BODY, TAIL: begin
                    if (xfer) begin
                        f_rec_frame_valid <= 1'b0;
                        f_ctrl_in         <= '0;
                        if (last) begin
                            frame_cnt <= frame_nxt;
                            bcnt      <= '0;
                            if (frame_nxt == num_q) begin
                                state            <= DONE;
                                done             <= 1'b1;
                                f_rec_data_valid <= 1'b0;
                                f_data_in        <= '0;
                                f_hi_priority    <= 1'b0;
                            end else if (gap_q != '0) begin
                                state            <= GAP;
                                gcnt             <= '0;
                                f_rec_data_valid <= 1'b0;
                                f_data_in        <= '0;
                                f_hi_priority    <= 1'b0;
                            end else begin
                                state             <= HEAD;
                                f_data_in         <= MARKER;
                                f_rec_frame_valid <= 1'b1;
                                f_ctrl_in         <= {len_q, len_q};
                                f_hi_priority     <= pri_of(mode_q, frame_nxt[0]);
                            end
                        end else begin
                            bcnt      <= nxt;
                            state     <= nst;
                            f_data_in <= nxt_data;
                        end
                    end
                end
                GAP: begin
                    if (gcnt == gap_q - GAP_W'(1)) begin
                        state             <= HEAD;
                        f_data_in         <= MARKER;
                        f_rec_data_valid  <= 1'b1;
                        f_rec_frame_valid <= 1'b1;
                        f_ctrl_in         <= {len_q, len_q};
                        f_hi_priority     <= pri_of(mode_q, frame_cnt[0]);
                    end else begin
                        gcnt <= gcnt + GAP_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
